// File: rtl/fetch_prefetch_if.sv
// Fetch/prefetch bus: memory read handshake, PC control and buffer output.
interface fetch_prefetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              enable_fetch;
  logic              enable_updatePC;
  logic              br_taken;
  logic [ADDR_W-1:0] taddr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_dout;
  logic              instrmem_rd;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_instr;
  logic [ADDR_W-1:0] dout_pc;
  logic [ADDR_W-1:0] dout_npc;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  enable_fetch, enable_updatePC, br_taken, taddr, imem_ack, imem_dout, dout_ready,
    output instrmem_rd, pc, npc, dout_valid, dout_instr, dout_pc, dout_npc, count
  );

  modport master (
    output enable_fetch, enable_updatePC, br_taken, taddr, imem_ack, imem_dout, dout_ready,
    input  instrmem_rd, pc, npc, dout_valid, dout_instr, dout_pc, dout_npc, count
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Instruction fetch unit: one outstanding memory read at a time, results
// collected into a first-word-fall-through prefetch buffer. A redirect
// flushes the buffer and discards any read already in flight.
module fetch_prefetch #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h3000
) (
  input  logic               clock,
  input  logic               reset,
  fetch_prefetch_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_rd;
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_mem_instr [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc    [DEPTH];
  logic [ADDR_W-1:0] r_mem_npc   [DEPTH];

  logic              w_redirect, w_issue, w_push, w_pop;
  logic [ADDR_W-1:0] w_npc;

  assign w_npc      = r_pc + ADDR_W'(1);
  assign w_redirect = bus.br_taken & bus.enable_updatePC;
  // A redirect in IDLE wins over issue; a full buffer blocks issue so a push
  // can never overflow.
  assign w_issue    = (r_state == IDLE) & bus.enable_fetch & bus.enable_updatePC &
                      ~bus.br_taken & (r_count < CNT_W'(DEPTH));
  // Ack data coinciding with a redirect belongs to the old stream.
  assign w_push     = (r_state == REQ) & bus.imem_ack & ~w_redirect;
  assign w_pop      = bus.dout_ready & (r_count != '0) & ~w_redirect;

  // Fetch FSM: owns pc and the registered read strobe.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_rd    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_redirect) begin
            r_pc <= bus.taddr;
          end else if (w_issue) begin
            r_state <= REQ;
            r_rd    <= 1'b1;
          end
        end
        REQ: begin
          if (w_redirect) begin
            r_pc <= bus.taddr;
            if (bus.imem_ack) begin
              r_state <= IDLE;
              r_rd    <= 1'b0;
            end else begin
              r_state <= DROP;
            end
          end else if (bus.imem_ack) begin
            r_pc    <= w_npc;
            r_state <= IDLE;
            r_rd    <= 1'b0;
          end
        end
        DROP: begin
          if (w_redirect) r_pc <= bus.taddr;
          if (bus.imem_ack) begin
            r_state <= IDLE;
            r_rd    <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rd    <= 1'b0;
        end
      endcase
    end
  end

  // Buffer bookkeeping: pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (w_redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Buffer storage; no reset needed, occupancy tracking gates visibility.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem_instr[r_wptr] <= bus.imem_dout;
      r_mem_pc[r_wptr]    <= r_pc;
      r_mem_npc[r_wptr]   <= w_npc;
    end
  end

  assign bus.instrmem_rd = r_rd;
  assign bus.pc          = r_pc;
  assign bus.npc         = w_npc;
  assign bus.count       = r_count;
  assign bus.dout_valid  = (r_count != '0);
  assign bus.dout_instr  = r_mem_instr[r_rptr];
  assign bus.dout_pc     = r_mem_pc[r_rptr];
  assign bus.dout_npc    = r_mem_npc[r_rptr];
endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with a scoreboard of expected buffer entries.
module tb_fetch_prefetch;
  logic clock;
  logic reset;
  int   nchk = 0;
  int   nerr = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] npc;
  } ent_t;

  ent_t q[$];

  fetch_prefetch_if #(.ADDR_W(16), .DATA_W(16), .DEPTH(4)) bus ();

  fetch_prefetch #(.ADDR_W(16), .DATA_W(16), .DEPTH(4), .RESET_PC(16'h3000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  function automatic logic [15:0] mdata(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset = 1'b0;
    bus.enable_fetch    = 1'b0;
    bus.enable_updatePC = 1'b0;
    bus.br_taken        = 1'b0;
    bus.taddr           = '0;
    bus.imem_ack        = 1'b0;
    bus.imem_dout       = '0;
    bus.dout_ready      = 1'b0;
    q.delete();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Wait for a read, check its address, answer it and queue the expected entry.
  task automatic fetch_one(input logic [15:0] a);
    int   n = 0;
    ent_t e;
    while (!bus.instrmem_rd && n < 20) begin
      tick();
      n++;
    end
    chk("rd_seen", bus.instrmem_rd, 1);
    chk("rd_pc", bus.pc, a);
    bus.imem_ack  = 1'b1;
    bus.imem_dout = mdata(a);
    e.instr = mdata(a);
    e.pc    = a;
    e.npc   = a + 16'd1;
    q.push_back(e);
    tick();
    bus.imem_ack = 1'b0;
    chk("rd_clear", bus.instrmem_rd, 0);
  endtask

  // Pop everything, comparing each head against the scoreboard.
  task automatic drain();
    int   n = 0;
    ent_t e;
    while (bus.dout_valid && n < 10) begin
      if (q.size() == 0) begin
        chk("sb_underflow", 1, 0);
        e = '0;
      end else begin
        e = q.pop_front();
      end
      chk("head_instr", bus.dout_instr, e.instr);
      chk("head_pc", bus.dout_pc, e.pc);
      chk("head_npc", bus.dout_npc, e.npc);
      bus.dout_ready = 1'b1;
      tick();
      bus.dout_ready = 1'b0;
      n++;
    end
    chk("sb_empty", q.size(), 0);
    chk("drained_valid", bus.dout_valid, 0);
    chk("drained_count", bus.count, 0);
  endtask

  initial begin
    // Reset state
    reset_dut();
    reset = 1'b0;
    #1;
    chk("rst_rd", bus.instrmem_rd, 0);
    chk("rst_pc", bus.pc, 16'h3000);
    chk("rst_npc", bus.npc, 16'h3001);
    chk("rst_count", bus.count, 0);
    chk("rst_valid", bus.dout_valid, 0);
    reset = 1'b1;

    // Fill the buffer; first issue lands on the first edge after release
    bus.enable_fetch    = 1'b1;
    bus.enable_updatePC = 1'b1;
    tick();
    chk("first_issue_rd", bus.instrmem_rd, 1);
    for (int i = 0; i < 4; i++) fetch_one(16'h3000 + 16'(i));
    chk("full_count", bus.count, 4);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("full_no_rd", bus.instrmem_rd, 0);
    end
    chk("full_head_pc", bus.dout_pc, q[0].pc);

    // One pop from full frees a slot; next read goes to 3004
    chk("pop1_instr", bus.dout_instr, q[0].instr);
    chk("pop1_pc", bus.dout_pc, 16'h3000);
    void'(q.pop_front());
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    chk("pop1_count", bus.count, 3);
    fetch_one(16'h3004);
    bus.enable_fetch = 1'b0;
    chk("refill_count", bus.count, 4);
    drain();

    // Redirect while read at 3001 is outstanding
    reset_dut();
    bus.enable_fetch    = 1'b1;
    bus.enable_updatePC = 1'b1;
    fetch_one(16'h3000);
    tick();
    chk("r1_rd", bus.instrmem_rd, 1);
    chk("r1_pc", bus.pc, 16'h3001);
    bus.br_taken = 1'b1;
    bus.taddr    = 16'h4000;
    tick();
    bus.br_taken = 1'b0;
    q.delete();
    chk("drop_count", bus.count, 0);
    chk("drop_valid", bus.dout_valid, 0);
    chk("drop_rd", bus.instrmem_rd, 1);
    chk("drop_pc", bus.pc, 16'h4000);
    tick();
    chk("drop_hold_rd", bus.instrmem_rd, 1);
    bus.imem_ack  = 1'b1;
    bus.imem_dout = 16'hBEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk("drop_ack_rd", bus.instrmem_rd, 0);
    chk("drop_ack_count", bus.count, 0);
    chk("drop_ack_pc", bus.pc, 16'h4000);
    fetch_one(16'h4000);
    bus.enable_fetch = 1'b0;
    chk("post_drop_count", bus.count, 1);
    drain();

    // PC wrap at FFFF
    bus.br_taken = 1'b1;
    bus.taddr    = 16'hFFFF;
    tick();
    bus.br_taken = 1'b0;
    chk("wrap_pc", bus.pc, 16'hFFFF);
    chk("wrap_npc", bus.npc, 16'h0000);
    bus.enable_fetch = 1'b1;
    fetch_one(16'hFFFF);
    bus.enable_fetch = 1'b0;
    chk("wrap_pc_after", bus.pc, 16'h0000);
    chk("wrap_npc_after", bus.npc, 16'h0001);
    chk("wrap_head_npc", bus.dout_npc, 16'h0000);
    drain();

    // Ack and redirect in the same cycle
    bus.enable_fetch = 1'b1;
    tick();
    chk("same_rd", bus.instrmem_rd, 1);
    chk("same_pc0", bus.pc, 16'h0000);
    bus.imem_ack     = 1'b1;
    bus.imem_dout    = 16'h1234;
    bus.br_taken     = 1'b1;
    bus.taddr        = 16'h5000;
    bus.enable_fetch = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    bus.br_taken = 1'b0;
    chk("same_rd_after", bus.instrmem_rd, 0);
    chk("same_pc", bus.pc, 16'h5000);
    chk("same_count", bus.count, 0);
    tick();
    chk("same_idle_rd", bus.instrmem_rd, 0);
    bus.enable_fetch = 1'b1;
    fetch_one(16'h5000);
    bus.enable_fetch = 1'b0;

    // br_taken without enable_updatePC is ignored
    bus.br_taken        = 1'b1;
    bus.enable_updatePC = 1'b0;
    bus.taddr           = 16'h7777;
    tick();
    bus.br_taken        = 1'b0;
    bus.enable_updatePC = 1'b1;
    chk("nobr_pc", bus.pc, 16'h5001);
    chk("nobr_count", bus.count, 1);

    // Dropping enables mid-read does not cancel it
    bus.enable_fetch = 1'b1;
    tick();
    chk("en_rd", bus.instrmem_rd, 1);
    chk("en_pc", bus.pc, 16'h5001);
    bus.enable_fetch    = 1'b0;
    bus.enable_updatePC = 1'b0;
    tick();
    chk("en_hold_rd", bus.instrmem_rd, 1);
    fetch_one(16'h5001);
    bus.enable_updatePC = 1'b1;
    chk("en_count", bus.count, 2);
    chk("en_pc_after", bus.pc, 16'h5002);
    drain();

    // Stray ack in IDLE is ignored
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("stray_count", bus.count, 0);
    chk("stray_pc", bus.pc, 16'h5002);

    // Asynchronous reset during an outstanding read with two entries buffered
    reset_dut();
    bus.enable_fetch    = 1'b1;
    bus.enable_updatePC = 1'b1;
    fetch_one(16'h3000);
    fetch_one(16'h3001);
    tick();
    chk("mid_rd", bus.instrmem_rd, 1);
    chk("mid_count", bus.count, 2);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_rd", bus.instrmem_rd, 0);
    chk("arst_pc", bus.pc, 16'h3000);
    chk("arst_valid", bus.dout_valid, 0);
    q.delete();
    tick();
    bus.enable_fetch = 1'b0;
    bus.imem_ack     = 1'b1;
    reset            = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    chk("post_rst_rd", bus.instrmem_rd, 0);
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_pc", bus.pc, 16'h3000);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/fetch_prefetch.md
FETCH_PREFETCH -- requirements
Module: fetch_prefetch

Interface
REQ-001 Parameter ADDR_W, default 16, PC and address width.
REQ-002 Parameter DATA_W, default 16, instruction word width.
REQ-003 Parameter DEPTH, default 4, prefetch buffer entries; power of two, >=2.
REQ-004 Parameter RESET_PC, default 16'h3000, PC value after reset.
REQ-005 clock  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 enable_fetch  input  1  permits issuing new memory reads.
REQ-008 enable_updatePC  input  1  permits PC change (issue commit and redirect).
REQ-009 br_taken  input  1  redirect request.
REQ-010 taddr  input  ADDR_W  redirect target.
REQ-011 imem_ack  input  1  memory returns data for the outstanding read.
REQ-012 imem_dout  input  DATA_W  instruction data, valid with imem_ack.
REQ-013 instrmem_rd  output  1  registered read request; high while a read is outstanding.
REQ-014 pc  output  ADDR_W  fetch address; stable while instrmem_rd=1.
REQ-015 npc  output  ADDR_W  pc+1, combinational.
REQ-016 dout_valid  output  1  buffer non-empty.
REQ-017 dout_ready  input  1  consumer pops the head entry when dout_valid=1.
REQ-018 dout_instr, dout_pc, dout_npc  output  DATA_W/ADDR_W/ADDR_W  head entry fields.
REQ-019 count  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-020 FSM states: IDLE, REQ (read outstanding), DROP (outstanding read to be discarded).
REQ-021 IDLE->REQ when enable_fetch=1, enable_updatePC=1, br_taken=0, count<DEPTH; instrmem_rd=1 from the next cycle.
REQ-022 REQ->IDLE on imem_ack=1: push {imem_dout, pc, pc+1}, pc<=pc+1; instrmem_rd=0 the next cycle.
REQ-023 Issue occurs only from IDLE; max throughput is one instruction per two cycles.
REQ-024 An imem_ack outside REQ/DROP is ignored.
REQ-025 Redirect (br_taken=1 and enable_updatePC=1) in any state: pc<=taddr, buffer flushed (count<=0), any pop that cycle ignored.
REQ-026 Redirect in REQ moves to DROP; redirect in IDLE suppresses issue that cycle and stays IDLE.
REQ-027 In DROP, instrmem_rd stays 1; on imem_ack, data discarded, pc unchanged, go IDLE; a further redirect in DROP updates pc and stays DROP.
REQ-028 Redirect in the same cycle as imem_ack in REQ: ack data discarded, pc<=taddr, go IDLE.
REQ-029 br_taken=1 with enable_updatePC=0 has no effect.
REQ-030 enable_fetch/enable_updatePC deassertion never cancels an outstanding read; it completes normally.
REQ-031 pc and npc arithmetic wraps modulo 2^ADDR_W (all-ones +1 = 0).
REQ-032 Buffer is first-word-fall-through circular FIFO; dout_* reflect the head combinationally.
REQ-033 Simultaneous push and pop leaves count unchanged; push at count=DEPTH cannot occur (REQ-021).
REQ-034 Pop when dout_valid=0 has no effect.

Reset
REQ-035 reset=0 asynchronously forces state IDLE, pc=RESET_PC, instrmem_rd=0, count=0, dout_valid=0, read/write pointers 0.
REQ-036 Reset mid-read discards the outstanding read; a later imem_ack is ignored per REQ-024.
REQ-037 First issue is possible on the first clock edge after reset release.

Verification
REQ-038 Release reset, enables=1, ack 1 cycle after each rd, dout_ready=0 -> fetches 3000..3003, count=4, instrmem_rd stays 0 while full.
REQ-039 Full buffer, dout_ready=1 for one cycle -> head 3000 popped, count=3, new read at pc=3004 issued.
REQ-040 Read at 3001 outstanding, br_taken=1, taddr=4000 -> state DROP, count=0, ack discarded, next read at pc=4000.
REQ-041 pc=FFFF, ack -> entry pc=FFFF npc=0000, pc=0000.
REQ-042 Simultaneous ack and redirect to 5000 -> no push, pc=5000, IDLE.
REQ-043 Assert reset during REQ with count=2 -> count=0, instrmem_rd=0, pc=3000 immediately; stray ack ignored.
